// File: rtl/palin_pkg.sv
// palin_pkg: shared definitions for the serial palindrome detector.
//   MODE_NOL / MODE_OL : encodings of the overlap input.
//   fill_width()       : width rule for the window fill counter.
//   is_palin()         : mirror compare of the low n bits of a 16-bit word.
package palin_pkg;

    localparam logic MODE_NOL = 1'b0;
    localparam logic MODE_OL  = 1'b1;

    // Fill runs 0..width inclusive, so it needs one more code than width.
    function automatic int fill_width(input int width);
        return $clog2(width + 1);
    endfunction

    // Bits at or above n are ignored; pairs beyond n/2 are masked off by
    // the i < n/2 guard so the loop bound stays constant.
    function automatic logic is_palin(input logic [15:0] w, input int n);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if ((i < n / 2) && (w[i] != w[n - 1 - i])) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/palin_window.sv
// palin_window: serial shift window and fill counter.
//   clk, rst          : clock, async active-high reset
//   clr               : synchronous clear of window and fill
//   in_valid          : accept serial_in on this edge
//   serial_in         : data bit, shifted in at bit 0
//   restart           : previous window was consumed; count fill from 0
//   win               : window contents as they will be after this edge
//   full              : fill will equal WIDTH after this edge
// win/full are the post-edge view so the top can register a detection on
// the same edge that accepts the completing bit.
module palin_window
    import palin_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    input  logic             serial_in,
    input  logic             restart,
    output logic [WIDTH-1:0] win,
    output logic             full
);

    localparam int FILL_W = fill_width(WIDTH);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(WIDTH);

    logic [WIDTH-1:0]  win_q;
    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] fill_eff;
    logic [FILL_W-1:0] fill_nxt;

    always_comb begin
        fill_eff = restart ? '0 : fill_q;
        win      = win_q;
        fill_nxt = fill_q;
        if (clr) begin
            win      = '0;
            fill_nxt = '0;
        end else if (in_valid) begin
            win      = {win_q[WIDTH-2:0], serial_in};
            fill_nxt = (fill_eff == FILL_MAX) ? FILL_MAX : fill_eff + FILL_W'(1);
        end
        full = (fill_nxt == FILL_MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_q  <= '0;
            fill_q <= '0;
        end else begin
            win_q  <= win;
            fill_q <= fill_nxt;
        end
    end

endmodule

// File: rtl/palin_detect_nbit.sv
// palin_detect_nbit: serial palindrome detector, Moore output.
//   clk, rst    : clock, async active-high reset
//   serial_in   : data bit, taken when in_valid=1
//   in_valid    : sample qualifier
//   overlap     : 1 = overlapping, 0 = non-overlapping detection
//   clr         : synchronous clear (wins over in_valid)
//   out         : registered, 1 while the current full window is palindromic
//   match_count : saturating count of detections since reset/clr
module palin_detect_nbit
    import palin_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_in,
    input  logic             in_valid,
    input  logic             overlap,
    input  logic             clr,
    output logic             out,
    output logic [CNT_W-1:0] match_count
);

    logic [WIDTH-1:0] win_nxt;
    logic             full_nxt;
    logic             restart;
    logic             accept;
    logic             det;

    // In non-overlap mode a detection consumes the window, so the next
    // accepted bit begins a fresh one.
    assign restart = (overlap == MODE_NOL) && out;
    assign accept  = in_valid && !clr;
    assign det     = full_nxt && is_palin(16'(win_nxt), WIDTH);

    palin_window #(
        .WIDTH(WIDTH)
    ) u_window (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .in_valid (in_valid),
        .serial_in(serial_in),
        .restart  (restart),
        .win      (win_nxt),
        .full     (full_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out <= 1'b0;
        end else if (clr) begin
            out <= 1'b0;
        end else if (accept) begin
            out <= det;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_count <= '0;
        end else if (clr) begin
            match_count <= '0;
        end else if (accept && det && (match_count != '1)) begin
            match_count <= match_count + CNT_W'(1);
        end
    end

endmodule

// File: doc/palin_detect_nbit.md
# palin_detect_nbit

Parametrised serial palindrome detector with a Moore-style output. It watches a qualified serial bit stream and flags every WIDTH-bit window that reads the same forwards and backwards. It generalises the fixed 3-bit overlapping detector to any window width. It adds run-time selection between overlapping and non-overlapping detection, a sample-enable qualifier, a synchronous clear, and a saturating detection counter for the lab datapath.

## Interface
- WIDTH, 5, window length in bits; legal range 2..16.
- CNT_W, 8, width of match_count.
- clk  input  1  rising-edge clock; the block's only clock.
- rst  input  1  asynchronous, active-high reset.
- serial_in  input  1  serial data bit; sampled only when in_valid=1.
- in_valid  input  1  sample qualifier; one bit is accepted per clk edge with in_valid=1.
- overlap  input  1  1 = overlapping detection, 0 = non-overlapping; sampled with each accepted bit.
- clr  input  1  synchronous clear of window, fill, out and match_count.
- out  output  1  registered; 1 while the current window is full and palindromic.
- match_count  output  CNT_W  saturating count of detections since reset or clr.

## Operation
- State consists of three parts:
  - win[WIDTH-1:0]: newest bit at win[0].
  - fill: range 0..WIDTH; counts valid bits in the window.
  - match_count.
- Reset (async, immediate) and clr (at the clk edge) set win=0, fill=0, out=0, match_count=0.
- Accepted bit (in_valid=1, clr=0):
  - win ← {win[WIDTH-2:0], serial_in}.
  - fill ← min(fill_eff+1, WIDTH).
  - fill_eff = 0 if overlap=0 and out=1 (the previous window was consumed by a detection); otherwise fill_eff = fill.
- Detection (det): next fill == WIDTH and next win[i] == next win[WIDTH-1-i] for all i < WIDTH/2.
- out ← det on every accepted bit. While in_valid=0, out, win and fill hold; serial_in is ignored.
- match_count ← match_count+1 on each det=1, saturating at all-ones (no wrap).
- Overlapping mode: consecutive accepted bits may each produce a detection.
- Non-overlapping mode: after a detection, the next accepted bit starts a new window with fill=1. The earliest next detection is therefore WIDTH accepted bits later.
- Mode change: takes effect on the next accepted bit. No flush occurs; only the fill_eff rule above applies.
- Priority: rst > clr > in_valid. clr together with in_valid discards the sample.

## Timing
- Reset values: out=0, match_count=0 (internal win=0, fill=0). rst deassertion is taken synchronously with no further sequencing.
- Latency: the edge that accepts the completing bit also updates out and match_count, so both are visible in the following cycle. There is no extra pipeline stage.
- out is glitch-free: driven directly from a flop.
- Throughput: one bit per clk.
- Boundary conditions:
  - Fewer than WIDTH bits accepted since reset, clr or a non-overlap detection: out=0, regardless of window contents.
  - Counter at all-ones: holds; out still pulses.
  - rst asserted mid-window: all outputs go to 0 asynchronously; the partial window is discarded.

## Structure
- Package palin_pkg holds:
  - localparams MODE_NOL=1'b0 and MODE_OL=1'b1.
  - function is_palin(input logic [15:0] w, input int n): generic mirror compare.
  - FILL_W = $clog2(WIDTH+1), the width rule for fill.
- Sub-module palin_window implements the shift register and fill counter, including the fill_eff rule. Ports: clk, rst, clr, in_valid, serial_in, restart; outputs win and full.
- The top level holds the detect compare, the out flop and the saturating counter.

## Test plan
- Fill (WIDTH=5, overlap=1): bits 0,0,0,0 → out=0 after each; fifth bit 0 → out=1, match_count=1.
- Overlap (WIDTH=5): stream 1,0,1,0,1,0,1 → out=1 after bits 5, 6 and 7; match_count=3.
- Non-overlap (WIDTH=5): stream 1,0,1,0,1,0,1,0,1,0 → out=1 only after bits 5 and 10; match_count=2.
- Gaps: insert idle cycles (in_valid=0, serial_in random) after a detection → out held at 1 and match_count unchanged until the next accepted bit.
- Saturation and clr (CNT_W=2, overlap=1): nine 1s → five detections, match_count stops at 3. Then clr with in_valid=1 → match_count=0, out=0, sample dropped, and the next 4 ones give out=0.
- Async reset: assert rst between clk edges mid-stream → out and match_count read 0 before the next edge. After release, 5 further bits are needed before any detection.
